// File: rtl/elbeth_fetch_pkg.sv
// Shared definitions for the elbeth instruction-fetch stage.
package elbeth_fetch_pkg;

    // Instruction presented to decode whenever IF/ID holds nothing real.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Exception code consumed by the downstream exception path.
    localparam logic [3:0] ECODE_INST_MISALIGNED = 4'd0;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

    // A fetch target must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/elbeth_if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer and decoder field split.
module elbeth_if_id_reg
    import elbeth_fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        flush_mis_i,
    input  logic [31:0] flush_pc_i,
    output logic        skid_full_o,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        misaligned_o,
    output logic [6:0]  opcode_o,
    output logic [4:0]  inst_0_o,
    output logic [2:0]  inst_1_o,
    output logic [4:0]  inst_2_o,
    output logic [4:0]  inst_3_o,
    output logic [6:0]  inst_4_o
);

    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic        id_v_q, id_v_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_mis_q, id_mis_d;

    // Next-state for IF/ID and skid: flush beats stall, skid drains before fresh data.
    always_comb begin
        skid_v_d    = skid_v_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        id_v_d      = id_v_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        id_mis_d    = id_mis_q;
        if (flush_i) begin
            skid_v_d = 1'b0;
            if (flush_mis_i) begin
                // Carry the faulting target to decode as a flagged NOP.
                id_v_d    = 1'b1;
                id_pc_d   = flush_pc_i;
                id_inst_d = NOP_INST;
                id_mis_d  = 1'b1;
            end else begin
                id_v_d    = 1'b0;
                id_inst_d = NOP_INST;
                id_mis_d  = 1'b0;
            end
        end else if (stall_i) begin
            if (load_i) begin
                skid_v_d    = 1'b1;
                skid_pc_d   = pc_i;
                skid_inst_d = inst_i;
            end else begin
                skid_v_d = skid_v_q;
            end
        end else if (skid_v_q) begin
            id_v_d      = 1'b1;
            id_pc_d     = skid_pc_q;
            id_inst_d   = skid_inst_q;
            id_mis_d    = 1'b0;
            skid_v_d    = load_i;
            skid_pc_d   = pc_i;
            skid_inst_d = inst_i;
        end else if (load_i) begin
            id_v_d    = 1'b1;
            id_pc_d   = pc_i;
            id_inst_d = inst_i;
            id_mis_d  = 1'b0;
        end else begin
            // Decode consumed the entry and nothing replaces it.
            id_v_d    = 1'b0;
            id_inst_d = NOP_INST;
            id_mis_d  = 1'b0;
        end
    end

    // IF/ID and skid storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_v_q    <= 1'b0;
            skid_pc_q   <= 32'd0;
            skid_inst_q <= NOP_INST;
            id_v_q      <= 1'b0;
            id_pc_q     <= 32'd0;
            id_inst_q   <= NOP_INST;
            id_mis_q    <= 1'b0;
        end else begin
            skid_v_q    <= skid_v_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            id_v_q      <= id_v_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_mis_q    <= id_mis_d;
        end
    end

    assign skid_full_o  = skid_v_q;
    assign valid_o      = id_v_q;
    assign pc_o         = id_pc_q;
    assign inst_o       = id_inst_q;
    assign misaligned_o = id_mis_q;
    assign opcode_o     = id_inst_q[6:0];
    assign inst_0_o     = id_inst_q[11:7];
    assign inst_1_o     = id_inst_q[14:12];
    assign inst_2_o     = id_inst_q[19:15];
    assign inst_3_o     = id_inst_q[24:20];
    assign inst_4_o     = id_inst_q[31:25];

endmodule

// File: rtl/elbeth_fetch.sv
// Instruction fetch: PC generation, single-outstanding imem handshake, redirect squash.
module elbeth_fetch
    import elbeth_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_pc_branch,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic [6:0]  opcode,
    output logic [4:0]  inst_0,
    output logic [2:0]  inst_1,
    output logic [4:0]  inst_2,
    output logic [4:0]  inst_3,
    output logic [6:0]  inst_4,
    output logic        id_fetch_misaligned
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         halt_pend_q, halt_pend_d;
    logic         req_s;
    logic         skid_full_s;
    logic         resp_load_s;
    logic         skid_stays_empty_s;
    logic         target_mis_s;

    assign target_mis_s       = is_misaligned(ex_pc_branch);
    assign resp_load_s        = imem_rvalid & (state_q == S_WAIT) & ~ex_branch_taken;
    assign skid_stays_empty_s = ~skid_full_s & ~(resp_load_s & id_stall);

    // Fetch FSM: redirect first, then grant/response handling per state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        halt_pend_d = halt_pend_q;
        req_s       = 1'b0;
        case (state_q)
            S_REQ: begin
                if (ex_branch_taken) begin
                    pc_d        = ex_pc_branch;
                    halt_pend_d = 1'b0;
                    state_d     = target_mis_s ? S_HALT : S_REQ;
                end else begin
                    req_s = ~skid_full_s;
                    if (req_s & imem_gnt) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_WAIT: begin
                if (ex_branch_taken) begin
                    pc_d = ex_pc_branch;
                    if (imem_rvalid) begin
                        halt_pend_d = 1'b0;
                        state_d     = target_mis_s ? S_HALT : S_REQ;
                    end else begin
                        halt_pend_d = target_mis_s;
                        state_d     = S_DROP;
                    end
                end else if (imem_rvalid) begin
                    // Back-to-back fetch only if the response will not occupy the skid.
                    req_s = skid_stays_empty_s;
                    if (req_s & imem_gnt) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DROP: begin
                if (ex_branch_taken) begin
                    pc_d = ex_pc_branch;
                    if (imem_rvalid) begin
                        halt_pend_d = 1'b0;
                        state_d     = target_mis_s ? S_HALT : S_REQ;
                    end else begin
                        halt_pend_d = target_mis_s;
                        state_d     = S_DROP;
                    end
                end else if (imem_rvalid) begin
                    halt_pend_d = 1'b0;
                    state_d     = halt_pend_q ? S_HALT : S_REQ;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_HALT: begin
                if (ex_branch_taken) begin
                    pc_d    = ex_pc_branch;
                    state_d = target_mis_s ? S_HALT : S_REQ;
                end else begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // FSM and PC state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= 32'd0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign imem_req  = req_s & ~rst;
    assign imem_addr = pc_q;

    elbeth_if_id_reg u_if_id (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_i       (resp_load_s),
        .pc_i         (req_pc_q),
        .inst_i       (imem_rdata),
        .stall_i      (id_stall),
        .flush_i      (ex_branch_taken),
        .flush_mis_i  (target_mis_s),
        .flush_pc_i   (ex_pc_branch),
        .skid_full_o  (skid_full_s),
        .valid_o      (id_valid),
        .pc_o         (id_pc),
        .inst_o       (id_instruction),
        .misaligned_o (id_fetch_misaligned),
        .opcode_o     (opcode),
        .inst_0_o     (inst_0),
        .inst_1_o     (inst_1),
        .inst_2_o     (inst_2),
        .inst_3_o     (inst_3),
        .inst_4_o     (inst_4)
    );

endmodule

// File: tb/tb_elbeth_fetch.sv
// Directed bench for elbeth_fetch with a simple single-outstanding memory model.
module tb_elbeth_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ex_branch_taken;
    logic [31:0] ex_pc_branch;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic [6:0]  opcode;
    logic [4:0]  inst_0;
    logic [2:0]  inst_1;
    logic [4:0]  inst_2;
    logic [4:0]  inst_3;
    logic [6:0]  inst_4;
    logic        id_fetch_misaligned;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          pend_v;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          lat;
    bit          last_fire;
    logic [31:0] last_addr;

    elbeth_fetch dut (
        .clk                 (clk),
        .rst                 (rst),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_gnt            (imem_gnt),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .ex_branch_taken     (ex_branch_taken),
        .ex_pc_branch        (ex_pc_branch),
        .id_stall            (id_stall),
        .id_valid            (id_valid),
        .id_pc               (id_pc),
        .id_instruction      (id_instruction),
        .opcode              (opcode),
        .inst_0              (inst_0),
        .inst_1              (inst_1),
        .inst_2              (inst_2),
        .inst_3              (inst_3),
        .inst_4              (inst_4),
        .id_fetch_misaligned (id_fetch_misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0200: return 32'h0050_0093;
            32'h0000_0204: return 32'h00a0_0113;
            32'h0000_0208: return 32'h00f0_0193;
            default:       return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: starts and ends just after a falling edge.
    task automatic tick();
        imem_rvalid = pend_v && (pend_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_word(pend_addr) : 32'h0;
        #1;
        last_fire = imem_req & imem_gnt;
        last_addr = imem_addr;
        @(posedge clk);
        if (imem_rvalid) pend_v = 1'b0;
        else if (pend_v) pend_cnt--;
        if (last_fire) begin
            pend_v    = 1'b1;
            pend_addr = last_addr;
            pend_cnt  = lat - 1;
        end
        @(negedge clk);
        imem_rvalid     = 1'b0;
        ex_branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        pend_v          = 1'b0;
        imem_gnt        = 1'b1;
        imem_rvalid     = 1'b0;
        ex_branch_taken = 1'b0;
        ex_pc_branch    = 32'h0;
        id_stall        = 1'b0;
        lat             = 1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && !id_valid; i++) tick();
        chk(tag, {31'd0, id_valid}, 32'd1);
    endtask

    initial begin
        rst             = 1'b1;
        imem_gnt        = 1'b1;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'h0;
        ex_branch_taken = 1'b0;
        ex_pc_branch    = 32'h0;
        id_stall        = 1'b0;
        pend_v          = 1'b0;
        pend_addr       = 32'h0;
        pend_cnt        = 0;
        lat             = 1;
        #2;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_inst", id_instruction, 32'h0000_0013);
        chk("rst_mis", {31'd0, id_fetch_misaligned}, 32'd0);

        // Basic streaming fetch, k=1
        do_reset();
        tick();
        chk("t1_addr0", last_addr, 32'h200);
        chk("t1_fire0", {31'd0, last_fire}, 32'd1);
        chk("t1_nvalid", {31'd0, id_valid}, 32'd0);
        tick();
        chk("t1_addr1", last_addr, 32'h204);
        chk("t1_valid", {31'd0, id_valid}, 32'd1);
        chk("t1_pc0", id_pc, 32'h200);
        chk("t1_opc", {25'd0, opcode}, 32'h13);
        chk("t1_rd", {27'd0, inst_0}, 32'd1);
        chk("t1_rs1", {27'd0, inst_2}, 32'd0);
        chk("t1_imm", {27'd0, inst_3}, 32'd5);
        tick();
        chk("t1_pc1", id_pc, 32'h204);
        chk("t1_inst1", id_instruction, 32'h00a0_0113);
        chk("t1_rd1", {27'd0, inst_0}, 32'd2);

        // Stall absorbs one response into the skid, no fetch while it is full
        do_reset();
        tick();
        tick();
        chk("t2_pc0", id_pc, 32'h200);
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_pc", id_pc, 32'h200);
            chk("t2_noreq", {31'd0, last_fire}, 32'd0);
        end
        id_stall = 1'b0;
        tick();
        chk("t2_noreq_drain", {31'd0, last_fire}, 32'd0);
        chk("t2_pc1", id_pc, 32'h204);
        chk("t2_inst1", id_instruction, 32'h00a0_0113);
        tick();
        chk("t2_addr2", last_addr, 32'h208);
        chk("t2_fire2", {31'd0, last_fire}, 32'd1);
        chk("t2_bubble", {31'd0, id_valid}, 32'd0);
        tick();
        chk("t2_pc2", id_pc, 32'h208);
        chk("t2_inst2", id_instruction, 32'h00f0_0193);

        // Redirect while a k=3 response is pending: late data is dropped
        do_reset();
        lat = 3;
        tick();
        chk("t3_fire0", last_addr, 32'h200);
        ex_branch_taken = 1'b1;
        ex_pc_branch    = 32'h400;
        tick();
        chk("t3_noreq_br", {31'd0, last_fire}, 32'd0);
        chk("t3_flush", {31'd0, id_valid}, 32'd0);
        tick();
        chk("t3_noreq_drop", {31'd0, last_fire}, 32'd0);
        tick();
        chk("t3_drop_data", {31'd0, id_valid}, 32'd0);
        chk("t3_noreq_drop2", {31'd0, last_fire}, 32'd0);
        tick();
        chk("t3_fire_tgt", last_addr, 32'h400);
        chk("t3_fire_tgt_v", {31'd0, last_fire}, 32'd1);
        wait_valid("t3_wait", 8);
        chk("t3_pc", id_pc, 32'h400);
        chk("t3_inst", id_instruction, 32'hC0DE_0400);

        // Redirect in the same cycle as rvalid
        do_reset();
        tick();
        tick();
        chk("t4_pc0", id_pc, 32'h200);
        ex_branch_taken = 1'b1;
        ex_pc_branch    = 32'h300;
        tick();
        chk("t4_flush", {31'd0, id_valid}, 32'd0);
        chk("t4_noreq", {31'd0, last_fire}, 32'd0);
        tick();
        chk("t4_addr", last_addr, 32'h300);
        chk("t4_fire", {31'd0, last_fire}, 32'd1);
        tick();
        chk("t4_pc", id_pc, 32'h300);

        // Misaligned redirect halts fetch until a new redirect
        do_reset();
        tick();
        ex_branch_taken = 1'b1;
        ex_pc_branch    = 32'h402;
        tick();
        chk("t5_valid", {31'd0, id_valid}, 32'd1);
        chk("t5_mis", {31'd0, id_fetch_misaligned}, 32'd1);
        chk("t5_pc", id_pc, 32'h402);
        chk("t5_inst", id_instruction, 32'h0000_0013);
        chk("t5_noreq", {31'd0, last_fire}, 32'd0);
        id_stall = 1'b1;
        tick();
        chk("t5_hold_mis", {31'd0, id_fetch_misaligned}, 32'd1);
        chk("t5_hold_pc", id_pc, 32'h402);
        chk("t5_noreq_h", {31'd0, last_fire}, 32'd0);
        id_stall = 1'b0;
        tick();
        chk("t5_consumed", {31'd0, id_valid}, 32'd0);
        chk("t5_mis_clr", {31'd0, id_fetch_misaligned}, 32'd0);
        chk("t5_noreq_h2", {31'd0, last_fire}, 32'd0);
        ex_branch_taken = 1'b1;
        ex_pc_branch    = 32'h500;
        tick();
        chk("t5_noreq_br", {31'd0, last_fire}, 32'd0);
        tick();
        chk("t5_resume", last_addr, 32'h500);
        chk("t5_resume_v", {31'd0, last_fire}, 32'd1);

        // Reset pulse with a request outstanding; stale rvalid after release
        do_reset();
        tick();
        lat = 2;
        tick();
        chk("t6_pre_valid", {31'd0, id_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, id_valid}, 32'd0);
        chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
        chk("t6_rst_inst", id_instruction, 32'h0000_0013);
        chk("t6_rst_addr", imem_addr, 32'h200);
        #1;
        rst      = 1'b0;
        imem_gnt = 1'b0;
        lat      = 1;
        tick();
        tick();
        chk("t6_stale_ign", {31'd0, id_valid}, 32'd0);
        imem_gnt = 1'b1;
        tick();
        chk("t6_addr", last_addr, 32'h200);
        chk("t6_fire", {31'd0, last_fire}, 32'd1);
        tick();
        chk("t6_valid", {31'd0, id_valid}, 32'd1);
        chk("t6_pc", id_pc, 32'h200);
        chk("t6_inst", id_instruction, 32'h0050_0093);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
